// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU, the result buffer and writeback.
// The buffer uses the slave view; the producer/consumer side uses master.
interface alu_result_buffer_if #(
  parameter int WIDTH   = 32,
  parameter int RD_BITS = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_s;
  logic               in_z;
  logic               in_cout;
  logic [RD_BITS-1:0] in_rd;
  logic               in_setf;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_s;
  logic [RD_BITS-1:0] out_rd;
  logic               flag_z;
  logic               flag_c;

  modport master (
    output in_valid, in_s, in_z, in_cout, in_rd, in_setf, flush, out_ready,
    input  in_ready, out_valid, out_s, out_rd, flag_z, flag_c
  );

  modport slave (
    input  in_valid, in_s, in_z, in_cout, in_rd, in_setf, flush, out_ready,
    output in_ready, out_valid, out_s, out_rd, flag_z, flag_c
  );
endinterface

// File: rtl/alu_result_buffer.sv
// 2-entry skid buffer between the ALU and writeback, plus the Z/C flag register.
// Optional ALU_RESULT_CNT_EN adds a saturating retire counter port.
module alu_result_buffer #(
  parameter int WIDTH   = 32,
  parameter int RD_BITS = 5
) (
  input  logic clk,
  input  logic reset,
  alu_result_buffer_if.slave bus
`ifdef ALU_RESULT_CNT_EN
  ,
  output logic [15:0] retire_cnt
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0]   s;
    logic [RD_BITS-1:0] rd;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state;
  entry_t head, tail, in_ent;
  logic   out_valid_q, in_ready_q, flag_z_q, flag_c_q;
  logic   push, pop;

  assign in_ent = '{s: bus.in_s, rd: bus.in_rd};
  assign push   = bus.in_valid & in_ready_q;
  assign pop    = out_valid_q & bus.out_ready;

  // out_valid/in_ready are decoded into registers alongside the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      head        <= '0;
      tail        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
    end else begin
      // flags track every accepted op, even one discarded by flush
      if (push && bus.in_setf) begin
        flag_z_q <= bus.in_z;
        flag_c_q <= bus.in_cout;
      end
      if (bus.flush) begin
        state       <= EMPTY;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b1;
      end else begin
        case (state)
          EMPTY: if (push) begin
            head        <= in_ent;
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
          ONE: begin
            if (push && !pop) begin
              tail       <= in_ent;
              state      <= FULL;
              in_ready_q <= 1'b0;
            end else if (pop && !push) begin
              state       <= EMPTY;
              out_valid_q <= 1'b0;
            end else if (push && pop) begin
              head <= in_ent;
            end
          end
          FULL: if (pop) begin
            head       <= tail;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
          default: begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_s     = head.s;
  assign bus.out_rd    = head.rd;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_c    = flag_c_q;

`ifdef ALU_RESULT_CNT_EN
  // a pop cancelled by flush does not retire anything
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      retire_cnt <= '0;
    else if (pop && !bus.flush && retire_cnt != 16'hFFFF)
      retire_cnt <= retire_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_alu_result_buffer;
  localparam int WIDTH   = 32;
  localparam int RD_BITS = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_result_buffer_if #(.WIDTH(WIDTH), .RD_BITS(RD_BITS)) bus ();

`ifdef ALU_RESULT_CNT_EN
  logic [15:0] retire_cnt;
  alu_result_buffer #(.WIDTH(WIDTH), .RD_BITS(RD_BITS)) dut (
    .clk(clk), .reset(reset), .bus(bus), .retire_cnt(retire_cnt));
`else
  alu_result_buffer #(.WIDTH(WIDTH), .RD_BITS(RD_BITS)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif

  typedef struct {
    logic [WIDTH-1:0]   s;
    logic [RD_BITS-1:0] rd;
  } ent_t;

  // reference model: FIFO contents of at most two, flag values, retire count
  ent_t        mq[$];
  logic        mz, mc;
  int unsigned mcnt;
  int n_cmp = 0;
  int n_err = 0;

  task automatic model_clear();
    mq.delete();
    mz = 1'b0;
    mc = 1'b0;
    mcnt = 0;
  endtask

  // apply one cycle of stimulus at a negedge, advance the model, return at next negedge
  task automatic drive(input logic v, input logic [WIDTH-1:0] s, input logic [RD_BITS-1:0] rd,
                       input logic z, input logic c, input logic setf, input logic fl,
                       input logic ordy);
    bit mpush, mpop;
    ent_t e;
    bus.in_valid = v;  bus.in_s = s;  bus.in_rd = rd;  bus.in_z = z;
    bus.in_cout = c;   bus.in_setf = setf; bus.flush = fl; bus.out_ready = ordy;
    mpush = v && (mq.size() < 2);
    mpop  = (mq.size() > 0) && ordy;
    if (mpush && setf) begin mz = z; mc = c; end
    if (fl) mq.delete();
    else begin
      if (mpop) begin void'(mq.pop_front()); if (mcnt != 32'hFFFF) mcnt++; end
      if (mpush) begin e.s = s; e.rd = rd; mq.push_back(e); end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, ordy);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_s = '0; bus.in_rd = '0; bus.in_z = 0; bus.in_cout = 0;
    bus.in_setf = 0; bus.flush = 0; bus.out_ready = 0;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_s !== '0 || bus.out_rd !== '0) begin n_err++; $display("FAIL reset_data got %h/%h want 0/0", bus.out_s, bus.out_rd); end
    n_cmp++; if ({bus.flag_z, bus.flag_c} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b%b want 00", bus.flag_z, bus.flag_c); end
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_single_pass();
    drive(1, 32'h0000_00FF, 5'd3, 0, 0, 0, 0, 1);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_s !== 32'hFF || bus.out_rd !== 5'd3) begin
      n_err++; $display("FAIL single_out got v=%b s=%h rd=%0d want v=1 s=ff rd=3", bus.out_valid, bus.out_s, bus.out_rd); end
    idle(1);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    drive(1, 32'h11, 5'd1, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1 got %b want 1", bus.in_ready); end
    drive(1, 32'h22, 5'd2, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full got %b want 0", bus.in_ready); end
    drive(1, 32'h33, 5'd3, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.out_s !== 32'h11 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold got %h want 11", bus.out_s); end
    idle(1);
    n_cmp++; if (bus.out_s !== 32'h22 || bus.out_rd !== 5'd2 || bus.out_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_second got %h want 22", bus.out_s); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready2 got %b want 1", bus.in_ready); end
    idle(1);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_third got v=%b s=%h want v=0", bus.out_valid, bus.out_s); end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'hA0 + i, 5'(i), 0, 0, 0, 0, 1);
      n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_s !== 32'hA0 + i) begin
        n_err++; $display("FAIL stream_%0d got r=%b v=%b s=%h want r=1 v=1 s=%h", i, bus.in_ready, bus.out_valid, bus.out_s, 32'hA0 + i); end
    end
    idle(1);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flags();
    drive(1, 32'h1, 5'd1, 1, 1, 1, 0, 1);
    n_cmp++; if ({bus.flag_z, bus.flag_c} !== 2'b11) begin n_err++; $display("FAIL flags_set got %b%b want 11", bus.flag_z, bus.flag_c); end
    drive(1, 32'h2, 5'd2, 0, 0, 0, 0, 1);
    n_cmp++; if ({bus.flag_z, bus.flag_c} !== 2'b11) begin n_err++; $display("FAIL flags_nosetf got %b%b want 11", bus.flag_z, bus.flag_c); end
    drive(1, 32'h3, 5'd3, 0, 0, 1, 0, 1);
    n_cmp++; if ({bus.flag_z, bus.flag_c} !== 2'b00) begin n_err++; $display("FAIL flags_clear got %b%b want 00", bus.flag_z, bus.flag_c); end
    idle(1);
  endtask

  task automatic test_flush();
    drive(1, 32'h44, 5'd4, 1, 0, 1, 0, 0);
    drive(1, 32'h55, 5'd5, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_prefull got %b want 0", bus.in_ready); end
    drive(0, '0, '0, 0, 0, 0, 1, 1);
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_state got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready); end
    n_cmp++; if ({bus.flag_z, bus.flag_c} !== 2'b10) begin n_err++; $display("FAIL flush_flags got %b%b want 10", bus.flag_z, bus.flag_c); end
    n_cmp++; if (bus.out_s !== 32'h44 || bus.out_rd !== 5'd4) begin n_err++; $display("FAIL flush_keep got %h/%0d want 44/4", bus.out_s, bus.out_rd); end
    // push with setf concurrent with flush: entry dropped, flags still taken
    drive(1, 32'h66, 5'd6, 0, 1, 1, 1, 0);
    n_cmp++; if (bus.out_valid !== 1'b0 || {bus.flag_z, bus.flag_c} !== 2'b01) begin
      n_err++; $display("FAIL flush_push got v=%b zc=%b%b want v=0 zc=01", bus.out_valid, bus.flag_z, bus.flag_c); end
  endtask

  task automatic test_async_reset();
    drive(1, 32'h77, 5'd7, 1, 1, 1, 0, 0);
    drive(1, 32'h88, 5'd8, 0, 1, 1, 0, 0);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.flag_c !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL areset got v=%b c=%b r=%b want v=0 c=0 r=1", bus.out_valid, bus.flag_c, bus.in_ready); end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    idle(1);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL areset_empty got %b want 0", bus.out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
      n_cmp++; if (bus.out_valid !== (mq.size() > 0) || bus.in_ready !== (mq.size() < 2)) begin
        n_err++; $display("FAIL rand_hs[%0d] got v=%b r=%b want depth %0d", i, bus.out_valid, bus.in_ready, mq.size()); end
      n_cmp++; if (bus.flag_z !== mz || bus.flag_c !== mc) begin
        n_err++; $display("FAIL rand_flags[%0d] got %b%b want %b%b", i, bus.flag_z, bus.flag_c, mz, mc); end
      if (mq.size() > 0) begin
        n_cmp++; if (bus.out_s !== mq[0].s || bus.out_rd !== mq[0].rd) begin
          n_err++; $display("FAIL rand_data[%0d] got %h/%0d want %h/%0d", i, bus.out_s, bus.out_rd, mq[0].s, mq[0].rd); end
      end
    end
  endtask

`ifdef ALU_RESULT_CNT_EN
  task automatic test_retire_cnt();
    pulse_reset();
    for (int i = 0; i < 5; i++) drive(1, 32'(i), 5'(i), 0, 0, 0, 0, 1);
    idle(1);
    n_cmp++; if (retire_cnt !== 16'd5) begin n_err++; $display("FAIL cnt_five got %0d want 5", retire_cnt); end
    drive(1, 32'h9, 5'd9, 0, 0, 0, 0, 0);
    drive(0, '0, '0, 0, 0, 0, 1, 0);
    n_cmp++; if (retire_cnt !== 16'd5) begin n_err++; $display("FAIL cnt_flush got %0d want 5", retire_cnt); end
    for (int i = 0; i < 65535; i++) drive(1, 32'(i), 5'(i), 0, 0, 0, 0, 1);
    idle(1);
    n_cmp++; if (retire_cnt !== 16'hFFFF || mcnt != 32'hFFFF) begin
      n_err++; $display("FAIL cnt_sat got %h want ffff", retire_cnt); end
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_single_pass();
    test_backpressure();
    test_streaming();
    test_flags();
    test_flush();
    test_async_reset();
    test_random();
`ifdef ALU_RESULT_CNT_EN
    test_retire_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
